srsystem_frame_decoder: RTL and testbench
=========================================

Name: srsystem_frame_decoder

Overview:
Downstream stage of the serial reception counter. Shifts the serial line in on every rxclk edge and decodes the frame when the counter flags frame-complete (rxf). Frame format: start, DATABITS data bits LSB-first, parity, stop. Checks the frame and holds the decoded byte in a one-entry output buffer with a valid/read handshake, sticky error flags and a saturating error count.

Parameters:
BITNUM, 11, total frame bits; must equal DATABITS+3 and match the counter stage's terminal count
DATABITS, 8, data bits per frame
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
rxclk  input  1  receive bit clock, rising edge active
clr  input  1  synchronous active-high reset
rxd  input  1  serial line sample, valid at each rxclk rising edge
rxf  input  1  frame-complete flag from counter stage; high for one rxclk period after the last frame bit
rd  input  1  consumer read strobe, sampled on rxclk
data  output  DATABITS  decoded data byte
data_valid  output  1  buffer holds an unread byte
parity_err  output  1  sticky: parity mismatch on an accepted frame
frame_err  output  1  sticky: start bit != 0 or stop bit != 1
overrun  output  1  sticky: frame completed while buffer full
err_cnt  output  8  saturating count of frames with any error

Behaviour:
- Reset: on any rxclk edge with clr=1, all registers clear: sr=0, rxf_q=0, data=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, err_cnt=0. clr takes priority over every other event.
- Shift register sr[BITNUM-1:0]: every edge, sr <= {rxd, sr[BITNUM-1:1]}. After BITNUM shifts, sr[0]=start, sr[DATABITS:1]=data, sr[DATABITS+1]=parity, sr[BITNUM-1]=stop.
- Decode trigger: rxf_q <= rxf. Decode fires on the edge where rxf=1 and rxf_q=0 (rising edge only). A held or re-asserted-without-drop rxf does not re-decode. Decode uses the pre-edge sr value, i.e. the last BITNUM bits.
- Checks at decode:
  - fe = (sr[0]!=0) | (sr[BITNUM-1]!=1).
  - pe = (^sr[DATABITS:1] ^ sr[DATABITS+1]) != PARITY_ODD.
- Output buffer FSM, states EMPTY/FULL:
  - EMPTY, decode: data <= sr[DATABITS:1]; data_valid=1 (latency: visible one edge after the rxf rising edge); parity_err |= pe; frame_err |= fe; go FULL. The byte is stored even if fe or pe is set.
  - FULL, rd=1 and no decode: data_valid <= 0; go EMPTY. data retains its last value.
  - FULL, decode and rd=0: overrun <= 1; new frame discarded; data unchanged; its pe/fe not merged.
  - FULL, decode and rd=1 on the same edge: read and write both succeed; data <= new byte; stay FULL; no overrun.
  - rd while EMPTY: ignored.
- err_cnt: increments by 1 on each decode where pe|fe|(overrun condition). Saturates at 255, no wrap.
- Sticky flags clear only on clr.
- Reset mid-frame: sr clears. A decode can be spuriously evaluated on partial sr contents if rxf rises fewer than BITNUM edges after clr. The counter stage guarantees this does not occur, because both stages are cleared together at frame start.

Test Plan:
- clr=1 for 2 edges with rxd toggling -> all outputs 0, data=0x00, err_cnt=0.
- Serial 0xA5, even parity (bits 0,1,0,1,0,0,1,0,1,0,1), then rxf pulse -> data=0xA5, data_valid=1 one edge after rxf rise, no error flags, err_cnt=0; rd pulse -> data_valid=0, data stays 0xA5.
- 0x3C sent with parity bit 1 (PARITY_ODD=0) -> data=0x3C, parity_err=1, err_cnt=1. Then 0x00 with stop bit 0 -> frame_err=1, err_cnt=2.
- Two valid frames 0x11 then 0x22, no rd between -> data=0x11, overrun=1, err_cnt=1. Third frame 0x33 with rd on its decode edge -> data=0x33, data_valid=1, no further err_cnt increment.
- rxf held high 3 edges after a frame of 0x5A -> exactly one decode, data=0x5A, overrun stays 0.
- Force 260 erroneous frames, reading each -> err_cnt=255 (saturated). clr -> err_cnt=0 and all flags 0.

Source files
------------

// File: rtl/srsystem_frame_decoder.sv
// Serial frame decoder: shifts rxd every rxclk edge, decodes on the rising edge of rxf,
// and holds the decoded byte in a one-entry buffer with sticky error flags.
module srsystem_frame_decoder #(
    parameter int BITNUM     = 11,
    parameter int DATABITS   = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                rxclk,
    input  logic                clr,
    input  logic                rxd,
    input  logic                rxf,
    input  logic                rd,
    output logic [DATABITS-1:0] data,
    output logic                data_valid,
    output logic                parity_err,
    output logic                frame_err,
    output logic                overrun,
    output logic [7:0]          err_cnt
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_q, state_d;
    logic [BITNUM-1:0]   sr_q;
    logic                rxf_q;
    logic [DATABITS-1:0] data_q, data_d;
    logic                pe_q, pe_d;
    logic                fe_q, fe_d;
    logic                ovr_q, ovr_d;
    logic [7:0]          cnt_q, cnt_d;

    logic decode, fe, pe, ovr_cond;

    // Decode looks at the pre-edge shift register, i.e. the last BITNUM bits received.
    assign decode   = rxf & ~rxf_q;
    assign fe       = sr_q[0] | ~sr_q[BITNUM-1];
    assign pe       = (^sr_q[DATABITS:1] ^ sr_q[DATABITS+1]) != PARITY_ODD;
    assign ovr_cond = decode && (state_q == FULL) && !rd;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            EMPTY: begin
                if (decode) begin
                    data_d  = sr_q[DATABITS:1];
                    pe_d    = pe_q | pe;
                    fe_d    = fe_q | fe;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (decode && rd) begin
                    // simultaneous read and write: buffer is refilled, stays FULL
                    data_d = sr_q[DATABITS:1];
                    pe_d   = pe_q | pe;
                    fe_d   = fe_q | fe;
                end else if (decode) begin
                    ovr_d = 1'b1;
                end else if (rd) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (decode && (pe || fe || ovr_cond) && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge rxclk) begin
        if (clr) begin
            state_q <= EMPTY;
            sr_q    <= '0;
            rxf_q   <= 1'b0;
            data_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= {rxd, sr_q[BITNUM-1:1]};
            rxf_q   <= rxf;
            data_q  <= data_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data       = data_q;
    assign data_valid = (state_q == FULL);
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ovr_q;
    assign err_cnt    = cnt_q;

endmodule

// File: tb/tb_srsystem_frame_decoder.sv
// Directed bench for srsystem_frame_decoder: hand-built frames, expected values computed inline.
module tb_srsystem_frame_decoder;

    logic       rxclk = 1'b0;
    logic       clr = 1'b1, rxd = 1'b1, rxf = 1'b0, rd = 1'b0;
    logic [7:0] data, err_cnt;
    logic       data_valid, parity_err, frame_err, overrun;

    int nchk = 0;
    int nfail = 0;

    srsystem_frame_decoder #(.BITNUM(11), .DATABITS(8), .PARITY_ODD(1'b0)) dut (
        .rxclk(rxclk), .clr(clr), .rxd(rxd), .rxf(rxf), .rd(rd),
        .data(data), .data_valid(data_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .err_cnt(err_cnt)
    );

    always #5 rxclk = ~rxclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic do_clr(input int n);
        clr = 1'b1; rxf = 1'b0; rd = 1'b0;
        for (int i = 0; i < n; i++) begin
            rxd = i[0];
            tick();
        end
        clr = 1'b0; rxd = 1'b1;
    endtask

    // Shift start, data LSB-first, parity (even, optionally inverted), stop; then rxf for 'hold' edges.
    task automatic send(input logic [7:0] d, input logic bad_par, input logic stop_b,
                        input logic rd_dec, input int hold);
        logic [10:0] bits;
        bits = {stop_b, (^d) ^ bad_par, d, 1'b0};
        rxf = 1'b0; rd = 1'b0;
        for (int i = 0; i < 11; i++) begin
            rxd = bits[i];
            tick();
        end
        rxd = 1'b1; rxf = 1'b1; rd = rd_dec;
        for (int i = 0; i < hold; i++) begin
            tick();
            rd = 1'b0;
        end
        rxf = 1'b0;
    endtask

    task automatic read_pulse();
        rd = 1'b1;
        tick();
        rd = 1'b0;
    endtask

    initial begin
        // Reset with rxd toggling
        do_clr(2);
        chk("rst_data", data, 8'h00);
        chk("rst_valid", data_valid, 0);
        chk("rst_pe", parity_err, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_cnt", err_cnt, 0);

        // rd while EMPTY is ignored
        read_pulse();
        chk("rd_empty_valid", data_valid, 0);

        // 0xA5, good even parity; check latency around the rxf edge
        begin
            logic [10:0] bits;
            bits = 11'b10_1010_0101_0;
            for (int i = 0; i < 11; i++) begin
                rxd = bits[i];
                tick();
            end
            chk("a5_pre_valid", data_valid, 0);
            rxd = 1'b1; rxf = 1'b1;
            tick();
            rxf = 1'b0;
        end
        chk("a5_data", data, 8'hA5);
        chk("a5_valid", data_valid, 1);
        chk("a5_pe", parity_err, 0);
        chk("a5_fe", frame_err, 0);
        chk("a5_cnt", err_cnt, 0);
        read_pulse();
        chk("a5_rd_valid", data_valid, 0);
        chk("a5_rd_data", data, 8'hA5);

        // 0x3C with parity bit inverted, then 0x00 with bad stop bit
        send(8'h3C, 1'b1, 1'b1, 1'b0, 1);
        chk("3c_data", data, 8'h3C);
        chk("3c_pe", parity_err, 1);
        chk("3c_fe", frame_err, 0);
        chk("3c_cnt", err_cnt, 1);
        read_pulse();
        send(8'h00, 1'b0, 1'b0, 1'b0, 1);
        chk("00_data", data, 8'h00);
        chk("00_fe", frame_err, 1);
        chk("00_pe_sticky", parity_err, 1);
        chk("00_cnt", err_cnt, 2);
        read_pulse();

        // Overrun: 0x11 then 0x22 unread, then 0x33 with rd on its decode edge
        do_clr(1);
        send(8'h11, 1'b0, 1'b1, 1'b0, 1);
        send(8'h22, 1'b0, 1'b1, 1'b0, 1);
        chk("ovr_data", data, 8'h11);
        chk("ovr_flag", overrun, 1);
        chk("ovr_valid", data_valid, 1);
        chk("ovr_cnt", err_cnt, 1);
        send(8'h33, 1'b0, 1'b1, 1'b1, 1);
        chk("rw_data", data, 8'h33);
        chk("rw_valid", data_valid, 1);
        chk("rw_cnt", err_cnt, 1);

        // rxf held high for three edges decodes once
        do_clr(1);
        send(8'h5A, 1'b0, 1'b1, 1'b0, 3);
        chk("hold_data", data, 8'h5A);
        chk("hold_valid", data_valid, 1);
        chk("hold_ovr", overrun, 0);
        chk("hold_cnt", err_cnt, 0);

        // Saturating error count
        do_clr(1);
        for (int n = 1; n <= 260; n++) begin
            send(n[7:0], 1'b1, 1'b1, 1'b0, 1);
            read_pulse();
            if (n == 254) chk("sat_254", err_cnt, 254);
            if (n == 255) chk("sat_255", err_cnt, 255);
        end
        chk("sat_260", err_cnt, 255);
        chk("sat_ovr", overrun, 0);
        do_clr(1);
        chk("clr_cnt", err_cnt, 0);
        chk("clr_pe", parity_err, 0);
        chk("clr_fe", frame_err, 0);
        chk("clr_ovr", overrun, 0);
        chk("clr_valid", data_valid, 0);
        chk("clr_data", data, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
